dmem_arbiter: RTL

- Shares the single-port synchronous data memory between the core's EXE-stage load/store path and an external requester (program loader / debug port).
- Sits between the EXE pipeline register outputs and the data memory.
- Drives a stall to the pipeline hold logic whenever the core loses arbitration.
- Core normally wins; a starvation counter and a bounded burst lock guarantee forward progress for both sides.

---
 rtl/core_types_pkg.sv | 26 ++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/core_types_pkg.sv
// Shared types for the data-memory path: grant owner encoding, memory request
// bundle (core, external and memory side all use the same layout), and
// default arbitration limits.
package core_types_pkg;

    localparam int unsigned DEF_MAX_STARVE = 8;
    localparam int unsigned DEF_MAX_BURST  = 4;
    localparam int unsigned ARB_CNT_W      = 8;   // covers limits up to 255
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned F3_W           = 3;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_EXT  = 1'b1
    } owner_e;

    typedef struct packed {
        logic              Rmem;
        logic              Wmem;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [F3_W-1:0]   f3;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data memory between the EXE-stage
// load/store path and an external requester (loader / debug port).
// Ports:
//   Clock, nReset                 clock, synchronous active-low reset
//   core_* (Rmem/Wmem/addr/...)   core request; core_stall holds the pipeline
//   ext_*  (valid/we/lock/...)    external request; ext_ready accepts it
//   ext_rvalid/ext_rdata          external read response, one cycle after grant
//   mem_* / mem_rdata             data memory interface
// Core wins by default; a starvation counter forces ext through, and a bounded
// ext_lock burst guarantees the core still gets a cycle.
module dmem_arbiter
    import core_types_pkg::*;
#(
    parameter int unsigned MAX_STARVE = DEF_MAX_STARVE,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              core_Rmem,
    input  logic              core_Wmem,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_data,
    input  logic [F3_W-1:0]   core_f3,
    output logic              core_stall,
    input  logic              ext_valid,
    output logic              ext_ready,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [F3_W-1:0]   ext_f3,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_Rmem,
    output logic              mem_Wmem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [F3_W-1:0]   mem_f3,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e                owner_q, owner_d;
    logic [ARB_CNT_W-1:0]  burst_q, burst_d;
    logic [ARB_CNT_W-1:0]  starve_q, starve_d;
    logic                  rvalid_q, rvalid_d;

    logic     core_req;
    logic     starve_max;
    logic     burst_ok;
    logic     grant_ext;
    logic     grant_core;
    mem_req_t mem_req;

    // State register: owner FSM, counters and read-response flag
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            owner_q  <= OWN_CORE;
            burst_q  <= '0;
            starve_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Grant decision, memory mux and next-state logic
    always_comb begin
        owner_d    = OWN_CORE;
        burst_d    = '0;
        starve_d   = '0;
        rvalid_d   = 1'b0;
        mem_req    = '0;

        core_req   = core_Rmem | core_Wmem;
        starve_max = (starve_q == ARB_CNT_W'(MAX_STARVE));
        burst_ok   = (owner_q == OWN_EXT) && ext_lock && (burst_q < ARB_CNT_W'(MAX_BURST));
        // Reset blocks every grant so the memory never sees a strobe
        grant_ext  = nReset & ext_valid & (~core_req | starve_max | burst_ok);
        grant_core = nReset & core_req & ~grant_ext;

        if (grant_ext) begin
            mem_req.Rmem = ~ext_we;
            mem_req.Wmem = ext_we;
            mem_req.addr = ext_addr;
            mem_req.data = ext_wdata;
            mem_req.f3   = ext_f3;
        end else if (nReset) begin
            // Address/data follow the core even with no grant; strobes only on grant
            mem_req.Rmem = core_Rmem & grant_core;
            mem_req.Wmem = core_Wmem & grant_core;
            mem_req.addr = core_addr;
            mem_req.data = core_data;
            mem_req.f3   = core_f3;
        end

        if (grant_ext) begin
            owner_d = OWN_EXT;
            // First ext beat after a core/idle cycle starts a new burst
            if (owner_q == OWN_EXT) begin
                burst_d = (burst_q == ARB_CNT_W'(MAX_BURST)) ? burst_q : burst_q + ARB_CNT_W'(1);
            end else begin
                burst_d = ARB_CNT_W'(1);
            end
        end

        if (ext_valid && !grant_ext) begin
            starve_d = starve_max ? starve_q : starve_q + ARB_CNT_W'(1);
        end

        rvalid_d = grant_ext & ~ext_we;
    end

    assign ext_ready  = grant_ext;
    assign core_stall = core_req & grant_ext;
    assign ext_rvalid = rvalid_q;
    assign ext_rdata  = mem_rdata;
    assign mem_Rmem   = mem_req.Rmem;
    assign mem_Wmem   = mem_req.Wmem;
    assign mem_addr   = mem_req.addr;
    assign mem_data   = mem_req.data;
    assign mem_f3     = mem_req.f3;

endmodule
